// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM generator: FSM state encoding and
// the default timing constants (also used as the MMIO WIDTH reset value).
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int unsigned DATA_W = 32;

  // 20 ms period at 100 MHz, 1.0 ms .. 2.5 ms pulse range
  localparam logic [31:0] DEF_PERIOD_CYCLES = 32'd2000000;
  localparam logic [31:0] DEF_MIN_WIDTH     = 32'd100000;
  localparam logic [31:0] DEF_MAX_WIDTH     = 32'd250000;
  localparam logic [31:0] DEF_RESET_WIDTH   = 32'd240000;
  localparam logic [31:0] DEF_SLEW_STEP     = 32'd2000;

endpackage

// File: rtl/servo_width_clamp.sv
// Combinational next-shadow-width calculation for servo_pwm_gen.
// Clamps the requested width into [MIN_WIDTH, MAX_WIDTH]; when the macro
// SERVO_SLEW_EN is defined the result is additionally rate-limited so the
// shadow moves by at most SLEW_STEP per load.
module servo_width_clamp
  import servo_pkg::*;
#(
  parameter logic [31:0] MIN_WIDTH = DEF_MIN_WIDTH,
  parameter logic [31:0] MAX_WIDTH = DEF_MAX_WIDTH,
  parameter logic [31:0] SLEW_STEP = DEF_SLEW_STEP
) (
  input  logic [DATA_W-1:0] width,
  input  logic [DATA_W-1:0] cur_width,
  output logic [DATA_W-1:0] next_width,
  output logic              clamped
);

  logic              below;
  logic              above;
  logic [DATA_W-1:0] tgt;

  // Full 32-bit unsigned range check; the clamp flag always reflects the raw request
  always_comb begin
    below   = (width < MIN_WIDTH);
    above   = (width > MAX_WIDTH);
    clamped = below | above;
    if (below) begin
      tgt = MIN_WIDTH;
    end else if (above) begin
      tgt = MAX_WIDTH;
    end else begin
      tgt = width;
    end
  end

`ifdef SERVO_SLEW_EN
  // Step toward the clamped target; both operands lie inside the legal range so no wrap
  always_comb begin
    next_width = tgt;
    if (tgt >= cur_width) begin
      if ((tgt - cur_width) > SLEW_STEP) begin
        next_width = cur_width + SLEW_STEP;
      end
    end else begin
      if ((cur_width - tgt) > SLEW_STEP) begin
        next_width = cur_width - SLEW_STEP;
      end
    end
  end
`else
  // Without rate limiting the clamped target is taken directly
  assign next_width = tgt;

  logic unused_slew;
  assign unused_slew = ^{cur_width, SLEW_STEP};
`endif

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: fixed-period PWM whose high time comes from a shadow
// copy of WIDTH, reloaded only at period boundaries so pulses are never torn.
// Optional feature macro: SERVO_SLEW_EN (rate-limits shadow width changes).
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter logic [31:0] PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter logic [31:0] MIN_WIDTH     = DEF_MIN_WIDTH,
  parameter logic [31:0] MAX_WIDTH     = DEF_MAX_WIDTH,
  parameter logic [31:0] RESET_WIDTH   = DEF_RESET_WIDTH,
  parameter logic [31:0] SLEW_STEP     = DEF_SLEW_STEP
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic [DATA_W-1:0] WIDTH,
  input  logic              ENABLE,
  output logic              PWM_OUT,
  output logic              PERIOD_START,
  output logic [DATA_W-1:0] ACTIVE_WIDTH,
  output logic              CLAMPED
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] cnt_reg, cnt_next;
  logic              pwm_reg, pwm_next;
  logic              pstart_reg, pstart_next;
  logic [DATA_W-1:0] active_reg;
  logic              clamped_reg;
  logic              load;
  logic [DATA_W-1:0] width_next;
  logic              clamp_flag;

  servo_width_clamp #(
    .MIN_WIDTH (MIN_WIDTH),
    .MAX_WIDTH (MAX_WIDTH),
    .SLEW_STEP (SLEW_STEP)
  ) u_clamp (
    .width      (WIDTH),
    .cur_width  (active_reg),
    .next_width (width_next),
    .clamped    (clamp_flag)
  );

  // Next-state logic: IDLE waits for ENABLE, HIGH counts the pulse, LOW finishes the period
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (ENABLE) begin
          load       = 1'b1;
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == active_reg - 1'b1) begin
          state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_reg == PERIOD_CYCLES - 1'b1) begin
          cnt_next = '0;
          if (ENABLE) begin
            load       = 1'b1;
            state_next = ST_HIGH;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
    // Output bits are precomputed so PWM_OUT and PERIOD_START come straight from flops
    pwm_next    = (state_next == ST_HIGH);
    pstart_next = load;
  end

  // State, counter, outputs and shadow width registers; reset takes effect immediately
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      pwm_reg     <= 1'b0;
      pstart_reg  <= 1'b0;
      active_reg  <= RESET_WIDTH;
      clamped_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      pwm_reg    <= pwm_next;
      pstart_reg <= pstart_next;
      if (load) begin
        active_reg  <= width_next;
        clamped_reg <= clamp_flag;
      end
    end
  end

  assign PWM_OUT      = pwm_reg;
  assign PERIOD_START = pstart_reg;
  assign ACTIVE_WIDTH = active_reg;
  assign CLAMPED      = clamped_reg;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed self-checking bench for servo_pwm_gen with small timing parameters
// (period 100, width range 10..80, reset width 50, slew step 5).
// Honours SERVO_SLEW_EN for the slew-rate scenario.
module tb_servo_pwm_gen;

  localparam logic [31:0] P_PERIOD = 32'd100;
  localparam logic [31:0] P_MIN    = 32'd10;
  localparam logic [31:0] P_MAX    = 32'd80;
  localparam logic [31:0] P_RESET  = 32'd50;
  localparam logic [31:0] P_SLEW   = 32'd5;

  logic        PCLK;
  logic        PRESERN;
  logic [31:0] WIDTH;
  logic        ENABLE;
  logic        PWM_OUT;
  logic        PERIOD_START;
  logic [31:0] ACTIVE_WIDTH;
  logic        CLAMPED;

  int n_checks = 0;
  int n_pass   = 0;

  servo_pwm_gen #(
    .PERIOD_CYCLES (P_PERIOD),
    .MIN_WIDTH     (P_MIN),
    .MAX_WIDTH     (P_MAX),
    .RESET_WIDTH   (P_RESET),
    .SLEW_STEP     (P_SLEW)
  ) dut (
    .PCLK         (PCLK),
    .PRESERN      (PRESERN),
    .WIDTH        (WIDTH),
    .ENABLE       (ENABLE),
    .PWM_OUT      (PWM_OUT),
    .PERIOD_START (PERIOD_START),
    .ACTIVE_WIDTH (ACTIVE_WIDTH),
    .CLAMPED      (CLAMPED)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the negedge at which PERIOD_START is visible
  task automatic wait_pstart(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge PCLK);
      if (PERIOD_START) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_pstart_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Starting at the first-cycle negedge of a period, sample one period.
  // Optionally changes WIDTH or drops ENABLE at a given sample index.
  task automatic run_period(input int chg_at, input logic [31:0] chg_val,
                            input int drop_at, input int limit,
                            output int hi, output int len, output int rises);
    logic prev;
    hi    = 0;
    len   = 0;
    rises = 0;
    prev  = 1'b1;
    do begin
      if (len == chg_at) WIDTH = chg_val;
      if (len == drop_at) ENABLE = 1'b0;
      if (PWM_OUT) hi++;
      if (PWM_OUT && !prev) rises++;
      prev = PWM_OUT;
      @(negedge PCLK);
      len++;
    end while (!PERIOD_START && len < limit);
  endtask

  // One ordinary period: checks high time, period length and a single clean pulse
  task automatic period(input string tag, input int exp_hi);
    int hi, len, rises;
    run_period(-1, 32'd0, -1, 300, hi, len, rises);
    $display("period %s: high=%0d len=%0d extra_rises=%0d", tag, hi, len, rises);
    check({tag, "_high"}, hi, exp_hi);
    check({tag, "_len"}, len, P_PERIOD);
    check({tag, "_rises"}, rises, 32'd0);
  endtask

  logic [31:0] t2_width [6] = '{32'd5, 32'd10, 32'd200, 32'd80, 32'hFFFF_FFFF, 32'd30};
  logic [31:0] t2_exp   [6] = '{32'd10, 32'd10, 32'd80, 32'd80, 32'd80, 32'd30};
  logic [31:0] t2_clmp  [6] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
`ifdef SERVO_SLEW_EN
  int t6_exp [5] = '{55, 60, 65, 70, 70};
`else
  int t6_exp [5] = '{70, 70, 70, 70, 70};
`endif

  initial begin
    int hi, len, rises;
    int prev_hi;

    PRESERN = 1'b0;
    WIDTH   = 32'd0;
    ENABLE  = 1'b0;
    repeat (3) @(negedge PCLK);

    // Reset state
    check("rst_pwm", {31'd0, PWM_OUT}, 32'd0);
    check("rst_pstart", {31'd0, PERIOD_START}, 32'd0);
    check("rst_active", ACTIVE_WIDTH, P_RESET);
    check("rst_clamped", {31'd0, CLAMPED}, 32'd0);
    PRESERN = 1'b1;
    repeat (2) @(negedge PCLK);
    check("idle_pwm", {31'd0, PWM_OUT}, 32'd0);

    // 1. Basic operation, WIDTH=30
    WIDTH  = 32'd30;
    ENABLE = 1'b1;
    wait_pstart("t1");
    check("t1_pwm_first", {31'd0, PWM_OUT}, 32'd1);
    check("t1_active", ACTIVE_WIDTH, 32'd30);
    check("t1_clamped", {31'd0, CLAMPED}, 32'd0);
    period("t1_p0", 30);
    period("t1_p1", 30);

    // 2. Clamping and range boundaries; each WIDTH is loaded at the end of the period run
    prev_hi = 30;
    for (int i = 0; i < 6; i++) begin
      WIDTH = t2_width[i];
      period($sformatf("t2_%0d", i), prev_hi);
      check($sformatf("t2_active_%0d", i), ACTIVE_WIDTH, t2_exp[i]);
      check($sformatf("t2_clamped_%0d", i), {31'd0, CLAMPED}, t2_clmp[i]);
      prev_hi = int'(t2_exp[i]);
    end

    // 3. Mid-period WIDTH change is deferred to the next boundary
    run_period(15, 32'd60, -1, 300, hi, len, rises);
    $display("period t3_chg: high=%0d len=%0d extra_rises=%0d", hi, len, rises);
    check("t3_chg_high", hi, 32'd30);
    check("t3_chg_len", len, P_PERIOD);
    check("t3_chg_rises", rises, 32'd0);
    WIDTH = 32'd30;
    period("t3_next", 60);

    // 4. ENABLE dropped mid-period: period completes, then IDLE
    run_period(-1, 32'd0, 10, 100, hi, len, rises);
    $display("period t4_drop: high=%0d len=%0d extra_rises=%0d", hi, len, rises);
    check("t4_drop_high", hi, 32'd30);
    check("t4_drop_rises", rises, 32'd0);
    check("t4_idle_pstart", {31'd0, PERIOD_START}, 32'd0);
    check("t4_idle_pwm", {31'd0, PWM_OUT}, 32'd0);
    repeat (3) @(negedge PCLK);
    check("t4_idle_pwm_hold", {31'd0, PWM_OUT}, 32'd0);
    check("t4_idle_pstart_hold", {31'd0, PERIOD_START}, 32'd0);
    ENABLE = 1'b1;
    @(negedge PCLK);
    check("t4_reen_pstart", {31'd0, PERIOD_START}, 32'd1);
    check("t4_reen_pwm", {31'd0, PWM_OUT}, 32'd1);
    period("t4_reen", 30);

    // 5. Asynchronous reset mid-pulse at cnt=20
    repeat (20) @(negedge PCLK);
    check("t5_pre_pwm", {31'd0, PWM_OUT}, 32'd1);
    #1 PRESERN = 1'b0;
    #1;
    check("t5_async_pwm", {31'd0, PWM_OUT}, 32'd0);
    check("t5_async_active", ACTIVE_WIDTH, P_RESET);
    check("t5_async_pstart", {31'd0, PERIOD_START}, 32'd0);
    @(negedge PCLK);
    WIDTH   = 32'd45;
    PRESERN = 1'b1;
    wait_pstart("t5");
    check("t5_active", ACTIVE_WIDTH, 32'd45);
    period("t5_first", 45);

    // 6. Shadow moving from reset width 50 toward 70 (rate-limited when slew is built in)
    #1 PRESERN = 1'b0;
    ENABLE = 1'b0;
    @(negedge PCLK);
    check("t6_rst_active", ACTIVE_WIDTH, P_RESET);
    WIDTH   = 32'd70;
    PRESERN = 1'b1;
    @(negedge PCLK);
    ENABLE = 1'b1;
    wait_pstart("t6");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t6_active_%0d", i), ACTIVE_WIDTH, t6_exp[i]);
      period($sformatf("t6_%0d", i), t6_exp[i]);
    end
    check("t6_clamped", {31'd0, CLAMPED}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
